window_accumulator: RTL and testbench
=====================================

# window_accumulator

Boxcar accumulate-and-dump stage in the DSP chain, immediately downstream of the window up-counter. Signed samples are summed while enabled. Each rising edge of the counter's roll-over flag closes the window. The closed window is presented as a raw sum plus a power-of-two average on a valid/ready output register, and results that cannot be delivered are flagged as overruns.

## Interface

**Parameters**
- DATA_WIDTH, 12: input sample and o_AVG width, signed two's complement.
- ACC_WIDTH, 22: accumulator and o_SUM width. Windows of up to 2^(ACC_WIDTH-DATA_WIDTH) samples are overflow-free.
- SHIFT, 10: arithmetic right shift applied to the sum to form o_AVG. This is log2 of the nominal window length.

**Ports**
- i_CLK, in, 1: clock, rising edge.
- i_RST, in, 1: reset, asynchronous, active-high.
- i_EN, in, 1: accumulate and window-close enable.
- i_SAMPLE, in, DATA_WIDTH: signed sample.
- i_SAMPLE_VALID, in, 1: i_SAMPLE is valid this cycle.
- i_ROLL, in, 1: window-close flag from the up-counter. Level input; only its rising edge is used.
- i_READY, in, 1: consumer accepts the output.
- o_SUM, out, ACC_WIDTH: latched window sum, signed.
- o_AVG, out, DATA_WIDTH: latched o_SUM >>> SHIFT, truncated to DATA_WIDTH.
- o_NSAMP, out, ACC_WIDTH-DATA_WIDTH+1: number of samples in the latched window, saturating.
- o_VALID, out, 1: output register holds an undelivered result.
- o_OVR, out, 1: sticky; a window closed while the output register was full.

## Operation

**Edge detection**
- roll_q registers i_ROLL every cycle, regardless of i_EN.
- close = i_EN & i_ROLL & ~roll_q.
- A level held across an enable transition never produces a close.

**Accumulation** (only when i_EN=1)
- If i_SAMPLE_VALID: acc += sign-extended i_SAMPLE and ncnt += 1. ncnt saturates at all-ones.
- acc wraps modulo 2^ACC_WIDTH.
- When i_EN=0: acc and ncnt hold.

**Close cycle**
- A sample valid in the close cycle belongs to the closing window.
- The closing values are next_sum = acc + sample and next_n = ncnt + 1.
- In the same cycle, acc and ncnt clear to 0.

**Output FSM**
- States: EMPTY and FULL.
- EMPTY + close: load o_SUM, o_AVG and o_NSAMP; move to FULL.
- FULL + i_READY: handshake completes.
  - Without close: move to EMPTY.
  - With close: load the new result and stay in FULL, with o_VALID continuously high.
- FULL + ~i_READY + close: keep the old result, discard the new one, set o_OVR. The accumulator still clears.
- o_VALID = (state == FULL). Output registers change only on load.
- o_VALID and the output data are independent of i_EN. The handshake continues while i_EN=0.

**o_OVR**
- Cleared only by reset.

**Reset**
- Every output, acc, ncnt and roll_q go to 0. State goes to EMPTY.
- Reset mid-window discards the partial sum.

## Timing

- i_ROLL is first sampled high at edge k, with roll_q=0 and i_EN=1:
  - o_VALID, o_SUM, o_AVG and o_NSAMP are valid after edge k.
  - The sample presented at edge k is included.
- A sample at edge k+1 is the first sample of the next window.
- Throughput is one window per close. Back-to-back closes (i_ROLL toggling every cycle) are supported only while i_READY=1.
- Handshake: transfer occurs on an edge with o_VALID & i_READY. The data is stable while o_VALID=1 and i_READY=0.
- There are no combinational paths from inputs to outputs.

## Structure

- Shared package (dsp_pkg): default DATA_WIDTH, ACC_WIDTH and SHIFT values, and the 1-bit output-state encoding (EMPTY=0, FULL=1).
- Sub-module rise_detect: holds roll_q and produces the close pulse, gated by enable. It is reused by other DSP stages that consume counter flags.
- The accumulator, counters and output FSM live in window_accumulator.

## Test plan

1. Reset, then i_EN=1. Four valid samples 100, -20, 7, 1, with i_ROLL rising alongside the 4th. Expect o_VALID=1, o_SUM=88, o_NSAMP=4, o_AVG=0 with SHIFT=10.
2. 1024 samples of 2047, with i_ROLL rising on the last. Expect o_SUM=2096128 and o_AVG=2047. Then 1024 samples of -2048: expect o_SUM=-2097152 and o_AVG=-2048.
3. Hold i_READY=0 across two closes. Expect the first result kept, o_OVR=1, and o_VALID held. Raise i_READY: o_VALID drops next edge and o_OVR stays 1.
4. i_READY=1 in the same cycle as a close with o_VALID=1. Expect the new sum loaded, o_VALID not deasserted, o_OVR=0.
5. i_ROLL held high while i_EN goes 0→1. Expect no close. i_EN=0 with valid samples: acc unchanged, confirmed by the sum of the next window.
6. Assert i_RST mid-window after 3 samples of 50. Expect all outputs 0 immediately (asynchronous). The next window after release sums only post-reset samples.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared defaults and encodings for the DSP chain stages.
package dsp_pkg;

    localparam int unsigned DSP_DATA_WIDTH = 12;
    localparam int unsigned DSP_ACC_WIDTH  = 22;
    localparam int unsigned DSP_SHIFT      = 10;

    // Output register state: EMPTY holds nothing, FULL holds an undelivered result.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage : dsp_pkg

// File: rtl/rise_detect.sv
// Rising-edge detector for counter flags, with the pulse gated by enable.
// The history flop tracks the level unconditionally, so a level already high
// when the enable arrives never produces a pulse.
module rise_detect (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_EN,
    input  logic i_LEVEL,
    output logic o_RISE_c
);

    logic roll_q;
    logic roll_d;

    // Next history value and gated rising-edge pulse.
    always_comb begin
        roll_d   = i_LEVEL;
        o_RISE_c = i_EN & i_LEVEL & ~roll_q;
    end

    // History flop for the level.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            roll_q <= 1'b0;
        end else begin
            roll_q <= roll_d;
        end
    end

endmodule : rise_detect

// File: rtl/window_accumulator.sv
// Boxcar accumulate-and-dump: sums signed samples over a window closed by the
// rising edge of the counter roll-over flag, and presents sum, average and
// sample count on a valid/ready output register with a sticky overrun flag.
module window_accumulator
    import dsp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DSP_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = DSP_ACC_WIDTH,
    parameter int unsigned SHIFT      = DSP_SHIFT
) (
    input  logic                                i_CLK,
    input  logic                                i_RST,
    input  logic                                i_EN,
    input  logic signed [DATA_WIDTH-1:0]        i_SAMPLE,
    input  logic                                i_SAMPLE_VALID,
    input  logic                                i_ROLL,
    input  logic                                i_READY,
    output logic signed [ACC_WIDTH-1:0]         o_SUM,
    output logic signed [DATA_WIDTH-1:0]        o_AVG,
    output logic [ACC_WIDTH-DATA_WIDTH:0]       o_NSAMP,
    output logic                                o_VALID,
    output logic                                o_OVR
);

    localparam int unsigned NSAMP_WIDTH = ACC_WIDTH - DATA_WIDTH + 1;
    localparam int unsigned EXT_WIDTH   = ACC_WIDTH - DATA_WIDTH;

    logic                          close_c;

    logic signed [ACC_WIDTH-1:0]   acc_q,   acc_d;
    logic [NSAMP_WIDTH-1:0]        ncnt_q,  ncnt_d;
    logic [0:0]                    state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   sum_q,   sum_d;
    logic signed [DATA_WIDTH-1:0]  avg_q,   avg_d;
    logic [NSAMP_WIDTH-1:0]        nsamp_q, nsamp_d;
    logic                          ovr_q,   ovr_d;

    logic signed [ACC_WIDTH-1:0]   addend;
    logic signed [ACC_WIDTH-1:0]   next_sum;
    logic [NSAMP_WIDTH-1:0]        next_n;
    logic                          load;

    rise_detect u_rise_detect (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_EN     (i_EN),
        .i_LEVEL  (i_ROLL),
        .o_RISE_c (close_c)
    );

    // Accumulator update, output FSM and result load.
    always_comb begin
        acc_d   = acc_q;
        ncnt_d  = ncnt_q;
        state_d = state_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        nsamp_d = nsamp_q;
        ovr_d   = ovr_q;
        load    = 1'b0;

        // Closing values include a sample valid in the close cycle.
        addend   = i_SAMPLE_VALID ? {{EXT_WIDTH{i_SAMPLE[DATA_WIDTH-1]}}, i_SAMPLE}
                                  : ACC_WIDTH'(0);
        next_sum = acc_q + addend;
        next_n   = (i_SAMPLE_VALID && (ncnt_q != {NSAMP_WIDTH{1'b1}}))
                   ? ncnt_q + NSAMP_WIDTH'(1) : ncnt_q;

        if (i_EN) begin
            acc_d  = next_sum;
            ncnt_d = next_n;
        end

        // Accumulator clears on every close, even when the result is dropped.
        if (close_c) begin
            acc_d  = ACC_WIDTH'(0);
            ncnt_d = NSAMP_WIDTH'(0);
        end

        case (state_q)
            ST_EMPTY: begin
                if (close_c) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (i_READY) begin
                    if (close_c) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (close_c) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (load) begin
            sum_d   = next_sum;
            avg_d   = DATA_WIDTH'(next_sum >>> SHIFT);
            nsamp_d = next_n;
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            acc_q   <= '0;
            ncnt_q  <= '0;
            state_q <= ST_EMPTY;
            sum_q   <= '0;
            avg_q   <= '0;
            nsamp_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ncnt_q  <= ncnt_d;
            state_q <= state_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            nsamp_q <= nsamp_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_SUM   = sum_q;
    assign o_AVG   = avg_q;
    assign o_NSAMP = nsamp_q;
    assign o_VALID = (state_q == ST_FULL);
    assign o_OVR   = ovr_q;

endmodule : window_accumulator

// File: tb/tb_window_accumulator.sv
// Testbench for window_accumulator: directed scenarios plus random traffic,
// checked every cycle against a window-level reference model.
module tb_window_accumulator;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 22;
    localparam int unsigned SH = 10;
    localparam int unsigned NW = AW - DW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          roll;
    logic          ready;
    logic [AW-1:0] o_sum;
    logic [DW-1:0] o_avg;
    logic [NW-1:0] o_nsamp;
    logic          o_valid;
    logic          o_ovr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: running window sum and count, plus the delivered-result register.
    int m_acc, m_n, m_sum, m_nsamp;
    bit m_roll, m_valid, m_ovr;

    window_accumulator dut (
        .i_CLK          (clk),
        .i_RST          (rst),
        .i_EN           (en),
        .i_SAMPLE       (sample),
        .i_SAMPLE_VALID (sample_valid),
        .i_ROLL         (roll),
        .i_READY        (ready),
        .o_SUM          (o_sum),
        .o_AVG          (o_avg),
        .o_NSAMP        (o_nsamp),
        .o_VALID        (o_valid),
        .o_OVR          (o_ovr)
    );

    always #5 clk = ~clk;

    // Interpret the low AW bits of v as a signed value.
    function automatic int sx(input int v);
        return (v <<< (32 - AW)) >>> (32 - AW);
    endfunction

    // Floor division (rounds toward minus infinity).
    function automatic int floor_div(input int s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_n = 0; m_sum = 0; m_nsamp = 0;
        m_roll = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic check_model();
        chk("valid", 32'(o_valid), 32'(m_valid));
        chk("sum",   32'(o_sum),   32'($unsigned(AW'(m_sum))));
        chk("avg",   32'(o_avg),   32'($unsigned(DW'(floor_div(sx(m_sum), 1 << SH)))));
        chk("nsamp", 32'(o_nsamp), 32'($unsigned(NW'(m_nsamp))));
        chk("ovr",   32'(o_ovr),   32'(m_ovr));
    endtask

    // One clock cycle: drive inputs, advance model at the edge, check after it.
    task automatic step(input bit e, input bit sv, input int smp, input bit r, input bit rdy);
        bit close;
        en = e; sample_valid = sv; sample = DW'(smp); roll = r; ready = rdy;
        @(posedge clk);
        close  = e && r && !m_roll;
        m_roll = r;
        if (e && sv) begin
            m_acc = m_acc + smp;
            if (m_n < (1 << NW) - 1) m_n = m_n + 1;
        end
        if (close) begin
            if (!m_valid || rdy) begin
                m_sum = m_acc; m_nsamp = m_n; m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            m_acc = 0; m_n = 0;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sample = '0; sample_valid = 1'b0; roll = 1'b0; ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        #2 rst = 1'b0;

        // 1: short mixed-sign window
        step(1, 1, 100, 0, 1);
        step(1, 1, -20, 0, 1);
        step(1, 1, 7, 0, 1);
        step(1, 1, 1, 1, 1);
        chk("t1_valid", 32'(o_valid), 32'd1);
        chk("t1_sum",   32'(o_sum),   32'd88);
        chk("t1_nsamp", 32'(o_nsamp), 32'd4);
        chk("t1_avg",   32'(o_avg),   32'd0);
        step(1, 0, 0, 0, 1);

        // 2: full-scale windows of nominal length
        for (int i = 0; i < 1023; i++) step(1, 1, 2047, 0, 1);
        step(1, 1, 2047, 1, 1);
        chk("t2_sum_pos", 32'(o_sum), 32'd2096128);
        chk("t2_avg_pos", 32'(o_avg), 32'd2047);
        chk("t2_n_pos",   32'(o_nsamp), 32'd1024);
        for (int i = 0; i < 1023; i++) step(1, 1, -2048, 0, 1);
        step(1, 1, -2048, 1, 1);
        chk("t2_sum_neg", 32'(o_sum), 32'($unsigned(AW'(-2097152))));
        chk("t2_avg_neg", 32'(o_avg), 32'($unsigned(DW'(-2048))));
        step(1, 0, 0, 0, 1);

        // 4: handshake and close in the same cycle
        step(1, 1, 10, 0, 0);
        step(1, 1, 20, 1, 0);
        chk("t4_first", 32'(o_sum), 32'd30);
        step(1, 1, 3, 0, 0);
        step(1, 1, 4, 1, 1);
        chk("t4_sum",   32'(o_sum),   32'd7);
        chk("t4_valid", 32'(o_valid), 32'd1);
        chk("t4_ovr",   32'(o_ovr),   32'd0);
        step(1, 0, 0, 0, 1);

        // 3: overrun while stalled
        step(1, 1, 11, 1, 0);
        step(1, 1, 2, 0, 0);
        step(1, 1, 2, 1, 0);
        chk("t3_kept",  32'(o_sum),   32'd11);
        chk("t3_ovr",   32'(o_ovr),   32'd1);
        chk("t3_valid", 32'(o_valid), 32'd1);
        step(1, 0, 0, 0, 1);
        chk("t3_drop",  32'(o_valid), 32'd0);
        chk("t3_stick", 32'(o_ovr),   32'd1);

        // 5: level held across enable, and disabled samples ignored
        step(0, 0, 0, 1, 1);
        step(1, 1, 5, 1, 1);
        chk("t5_noclose", 32'(o_valid), 32'd0);
        step(1, 1, 5, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1000, 0, 1);
        step(1, 1, 6, 1, 1);
        chk("t5_sum",   32'(o_sum),   32'd16);
        chk("t5_nsamp", 32'(o_nsamp), 32'd3);
        step(1, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int smp;
            smp = int'($urandom_range(0, 4095)) - 2048;
            step(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, smp,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
        end

        // 6: asynchronous reset mid-window
        step(1, 0, 0, 0, 1);
        step(1, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 50, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(o_valid), 32'd0);
        chk("t6_sum",   32'(o_sum),   32'd0);
        chk("t6_avg",   32'(o_avg),   32'd0);
        chk("t6_nsamp", 32'(o_nsamp), 32'd0);
        chk("t6_ovr",   32'(o_ovr),   32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 1, 9, 0, 1);
        step(1, 1, 9, 0, 1);
        step(1, 1, 9, 1, 1);
        chk("t6_sum_post", 32'(o_sum),   32'd27);
        chk("t6_n_post",   32'(o_nsamp), 32'd3);
        step(1, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_window_accumulator
